// File: rtl/updown_count_seq_pkg.sv
// Shared definitions for the up/down count sequencer.
//   state_t  : sequencer FSM state encoding
//   DIR_UP   : cmd_dir value selecting count-up
//   DIR_DOWN : cmd_dir value selecting count-down
package updown_count_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_count_core.sv
// Loadable WIDTH-bit up/down counter.
//   clk      : clock, posedge
//   reset    : synchronous active-high reset, clears count
//   load     : load load_val (takes priority over enable)
//   load_val : value loaded when load=1
//   enable   : step count by one in the direction given by up_down
//   up_down  : 1 = increment, 0 = decrement (wraps modulo 2^WIDTH)
//   count    : current counter value
// Holds its value when neither load nor enable is asserted.
module updown_count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable) begin
            if (up_down) begin
                count <= count + WIDTH'(1);
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/updown_count_sequencer.sv
// Command-driven sequencer for an up/down counter. A {start, target, dir}
// command is accepted over a valid/ready handshake; the counter is loaded
// with start and then stepped once per cycle toward target, after which
// done pulses for one cycle.
//   clk        : clock, posedge
//   reset      : synchronous active-high reset
//   cmd_valid  : command present
//   cmd_ready  : command can be accepted (IDLE and not in reset)
//   cmd_start  : value loaded into the counter
//   cmd_target : value at which counting stops
//   cmd_dir    : 1 = count up, 0 = count down
//   count      : current counter value
//   busy       : high in every state other than IDLE
//   done       : one-cycle completion pulse, count == target
// Optional feature, enabled by defining CNT_SEQ_ABORT_EN:
//   abort      : in LOAD or RUN, return to IDLE next edge with count frozen
//   aborted    : one-cycle pulse after an abort was taken
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | counter holds, cmd_ready high, waiting for a command
// ST_LOAD | counter loads latched start value
// ST_RUN  | counter steps once per cycle until it reaches target
// ST_DONE | done pulse, count holds target
module updown_count_sequencer
    import updown_count_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_dir,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
`ifdef CNT_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] target_q;
    logic             dir_q;
    logic             accept;
    logic             ctr_load;
    logic             ctr_en;
    logic [WIDTH-1:0] step_val;
    logic             abort_hit;

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

    // Value the counter will hold after this edge while running; leaving RUN
    // on this compare is what keeps the counter from overshooting target.
    assign step_val = (dir_q == DIR_UP) ? (count + WIDTH'(1)) : (count - WIDTH'(1));

`ifdef CNT_SEQ_ABORT_EN
    assign abort_hit = abort && ((state_q == ST_LOAD) || (state_q == ST_RUN));

    always_ff @(posedge clk) begin
        if (reset) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort_hit;
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q  <= '0;
            target_q <= '0;
            dir_q    <= DIR_UP;
        end else if (accept) begin
            start_q  <= cmd_start;
            target_q <= cmd_target;
            dir_q    <= cmd_dir;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ctr_load = 1'b1;
                state_d  = (start_q == target_q) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                ctr_en = 1'b1;
                if (step_val == target_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // An abort suppresses whatever load/step was scheduled so count freezes.
        if (abort_hit) begin
            state_d  = ST_IDLE;
            ctr_load = 1'b0;
            ctr_en   = 1'b0;
        end
    end

    updown_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (start_q),
        .enable   (ctr_en),
        .up_down  (dir_q),
        .count    (count)
    );

endmodule

// File: tb/tb_updown_count_sequencer.sv
module tb_updown_count_sequencer;

    typedef struct packed {
        logic [3:0] cnt;
        logic       dn;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_start;
    logic [3:0] cmd_target;
    logic       cmd_dir;
    logic [3:0] count;
    logic       busy;
    logic       done;
`ifdef CNT_SEQ_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];

    updown_count_sequencer #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_target (cmd_target),
        .cmd_dir    (cmd_dir),
        .count      (count),
        .busy       (busy),
        .done       (done)
`ifdef CNT_SEQ_ABORT_EN
        ,
        .abort      (abort),
        .aborted    (aborted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command, waits for acceptance and queues the expected
    // per-cycle count/done trace starting one edge after the accept edge.
    task automatic issue(input logic [3:0] s, input logic [3:0] t, input logic d);
        logic [3:0] n;
        logic [3:0] v;
        int         waited;
        cmd_start  = s;
        cmd_target = t;
        cmd_dir    = d;
        cmd_valid  = 1'b1;
        waited     = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!cmd_ready) check_val("ready_timeout", 32'(cmd_ready), 32'd1);
        tick();
        n = d ? (t - s) : (s - t);
        v = s;
        for (int i = 0; i <= int'(n); i++) begin
            exp_q.push_back('{cnt: v, dn: (i == int'(n))});
            v = d ? (v + 4'd1) : (v - 4'd1);
        end
        check_val("load_busy", 32'(busy), 32'd1);
        check_val("load_done", 32'(done), 32'd0);
        check_val("load_ready", 32'(cmd_ready), 32'd0);
    endtask

    task automatic drain();
        exp_t       e;
        logic [3:0] last;
        last = 4'd0;
        while (exp_q.size() > 0) begin
            tick();
            e    = exp_q.pop_front();
            last = e.cnt;
            check_val("count", 32'(count), 32'(e.cnt));
            check_val("done", 32'(done), 32'(e.dn));
            check_val("busy", 32'(busy), 32'd1);
            check_val("ready_busy", 32'(cmd_ready), 32'd0);
        end
        tick();
        check_val("ready_back", 32'(cmd_ready), 32'd1);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_done", 32'(done), 32'd0);
        check_val("idle_count", 32'(count), 32'(last));
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_start  = 4'd0;
        cmd_target = 4'd0;
        cmd_dir    = 1'b1;
`ifdef CNT_SEQ_ABORT_EN
        abort      = 1'b0;
`endif
        tick();
        tick();
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        tick();
        check_val("post_rst_ready", 32'(cmd_ready), 32'd1);

        issue(4'd3, 4'd7, 1'b1);
        cmd_valid = 1'b0;
        drain();

        issue(4'd1, 4'd14, 1'b0);
        cmd_valid = 1'b0;
        drain();

        issue(4'd14, 4'd1, 1'b1);
        cmd_valid = 1'b0;
        drain();

        issue(4'd9, 4'd9, 1'b0);
        cmd_valid = 1'b0;
        drain();

        // Second command held valid throughout the first one's run.
        issue(4'd5, 4'd6, 1'b1);
        cmd_start  = 4'd0;
        cmd_target = 4'd2;
        cmd_dir    = 1'b1;
        drain();
        issue(4'd0, 4'd2, 1'b1);
        cmd_valid = 1'b0;
        drain();

        // Reset in the middle of a run.
        issue(4'd0, 4'd9, 1'b1);
        cmd_valid = 1'b0;
        exp_q.delete();
        repeat (6) tick();
        check_val("mid_count", 32'(count), 32'd5);
        reset = 1'b1;
        tick();
        check_val("midrst_count", 32'(count), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        check_val("midrst_done2", 32'(done), 32'd0);
        check_val("midrst_ready", 32'(cmd_ready), 32'd1);

`ifdef CNT_SEQ_ABORT_EN
        issue(4'd0, 4'd9, 1'b1);
        cmd_valid = 1'b0;
        exp_q.delete();
        repeat (6) tick();
        check_val("abort_pre_count", 32'(count), 32'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_count", 32'(count), 32'd5);
        check_val("abort_pulse", 32'(aborted), 32'd1);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        tick();
        check_val("abort_pulse_end", 32'(aborted), 32'd0);
        check_val("abort_hold", 32'(count), 32'd5);
        check_val("abort_done2", 32'(done), 32'd0);
        check_val("abort_ready", 32'(cmd_ready), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
